// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader.
// Takes a length-prefixed, XOR-checksummed byte stream, packs it into little-endian
// 32-bit words, writes them to imem at ascending byte addresses, and releases the
// core from reset only after the whole image has arrived and its checksum matches.
module imem_loader #(
    parameter int unsigned P_DATA_WIDTH = 32,
    parameter int unsigned P_ADDR_WIDTH = 11
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_start,
    input  logic                    i_byte_valid,
    input  logic [7:0]              i_byte_data,
    output logic                    o_byte_ready,
    output logic                    o_imem_we,
    output logic [P_ADDR_WIDTH-1:0] o_imem_waddr,
    output logic [P_DATA_WIDTH-1:0] o_imem_wdata,
    output logic                    o_core_rst_n,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_err,
    output logic [1:0]              o_err_code
);

    typedef enum logic [2:0] {
        StIdle,
        StLen0,
        StLen1,
        StData,
        StCsum,
        StDone,
        StErr
    } state_e;

    // Largest accepted word count: the whole imem.
    localparam logic [16:0] LP_CAP = 17'(1 << (P_ADDR_WIDTH - 2));

    state_e                  r_state;
    state_e                  w_state_next;
    logic                    w_byte_ready;
    logic                    w_busy;
    logic                    w_start;
    logic                    w_xfer;
    logic [15:0]             w_len;
    logic                    w_len_ovf;

    logic [7:0]              r_len_lo;
    logic [15:0]             r_words_left;
    logic [1:0]              r_byte_idx;
    logic [23:0]             r_word;
    logic [7:0]              r_csum;
    logic [P_ADDR_WIDTH-1:0] r_addr;
    logic                    r_imem_we;
    logic [P_ADDR_WIDTH-1:0] r_imem_waddr;
    logic [P_DATA_WIDTH-1:0] r_imem_wdata;
    logic [1:0]              r_err_code;

    assign w_xfer    = i_byte_valid && w_byte_ready;
    assign w_len     = {i_byte_data, r_len_lo};
    assign w_len_ovf = ({1'b0, w_len} > LP_CAP);

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode; ready/busy follow directly from the current state.
    always_comb begin
        w_state_next = r_state;
        w_byte_ready = 1'b0;
        w_busy       = 1'b0;
        w_start      = 1'b0;
        case (r_state)
            StIdle, StDone, StErr: begin
                if (i_start) begin
                    w_start      = 1'b1;
                    w_state_next = StLen0;
                end
            end
            StLen0: begin
                w_byte_ready = 1'b1;
                w_busy       = 1'b1;
                if (i_byte_valid) w_state_next = StLen1;
            end
            StLen1: begin
                w_byte_ready = 1'b1;
                w_busy       = 1'b1;
                if (i_byte_valid) begin
                    if (w_len_ovf)          w_state_next = StErr;
                    else if (w_len == 16'd0) w_state_next = StCsum;
                    else                     w_state_next = StData;
                end
            end
            StData: begin
                w_byte_ready = 1'b1;
                w_busy       = 1'b1;
                if (i_byte_valid && r_byte_idx == 2'd3 && r_words_left == 16'd1) begin
                    w_state_next = StCsum;
                end
            end
            StCsum: begin
                w_byte_ready = 1'b1;
                w_busy       = 1'b1;
                if (i_byte_valid) begin
                    w_state_next = (i_byte_data == r_csum) ? StDone : StErr;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    // Datapath: length capture, word assembly, running checksum and write strobe.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_len_lo     <= '0;
            r_words_left <= '0;
            r_byte_idx   <= '0;
            r_word       <= '0;
            r_csum       <= '0;
            r_addr       <= '0;
            r_imem_we    <= 1'b0;
            r_imem_waddr <= '0;
            r_imem_wdata <= '0;
            r_err_code   <= '0;
        end else begin
            r_imem_we <= 1'b0;
            if (w_start) begin
                r_err_code <= 2'b00;
                r_addr     <= '0;
                r_csum     <= '0;
                r_byte_idx <= '0;
            end
            if (w_xfer) begin
                r_csum <= r_csum ^ i_byte_data;
                case (r_state)
                    StLen0: r_len_lo <= i_byte_data;
                    StLen1: begin
                        r_words_left <= w_len;
                        if (w_len_ovf) r_err_code <= 2'b01;
                    end
                    StData: begin
                        r_byte_idx <= r_byte_idx + 2'd1;
                        unique case (r_byte_idx)
                            2'd0: r_word[7:0]   <= i_byte_data;
                            2'd1: r_word[15:8]  <= i_byte_data;
                            2'd2: r_word[23:16] <= i_byte_data;
                            2'd3: begin
                                r_imem_we    <= 1'b1;
                                r_imem_waddr <= r_addr;
                                r_imem_wdata <= {i_byte_data, r_word};
                                r_addr       <= r_addr + P_ADDR_WIDTH'(4);
                                r_words_left <= r_words_left - 16'd1;
                            end
                        endcase
                    end
                    StCsum: begin
                        if (i_byte_data != r_csum) r_err_code <= 2'b10;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign o_byte_ready = w_byte_ready;
    assign o_busy       = w_busy;
    assign o_done       = (r_state == StDone);
    assign o_err        = (r_state == StErr);
    assign o_core_rst_n = (r_state == StDone);
    assign o_err_code   = r_err_code;
    assign o_imem_we    = r_imem_we;
    assign o_imem_waddr = r_imem_waddr;
    assign o_imem_wdata = r_imem_wdata;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: a stream-level model predicts imem writes and
// final status; one process checks every write strobe against the predicted list.
module tb_imem_loader;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_start;
    logic        i_byte_valid;
    logic [7:0]  i_byte_data;
    logic        o_byte_ready;
    logic        o_imem_we;
    logic [10:0] o_imem_waddr;
    logic [31:0] o_imem_wdata;
    logic        o_core_rst_n;
    logic        o_busy;
    logic        o_done;
    logic        o_err;
    logic [1:0]  o_err_code;

    int total = 0;
    int bad   = 0;

    logic [7:0]  m_stream[$];
    logic [10:0] exp_addr[$];
    logic [31:0] exp_data[$];
    logic        m_done;
    logic        m_err;
    logic [1:0]  m_code;

    imem_loader #(
        .P_DATA_WIDTH(32),
        .P_ADDR_WIDTH(11)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_start     (i_start),
        .i_byte_valid(i_byte_valid),
        .i_byte_data (i_byte_data),
        .o_byte_ready(o_byte_ready),
        .o_imem_we   (o_imem_we),
        .o_imem_waddr(o_imem_waddr),
        .o_imem_wdata(o_imem_wdata),
        .o_core_rst_n(o_core_rst_n),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_err       (o_err),
        .o_err_code  (o_err_code)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Stream-level model: parse length, list complete words among the first n_avail
    // bytes, and judge the checksum byte if it was sent.
    task automatic model_load(input int n_avail);
        int unsigned len;
        logic [7:0]  x;
        m_done = 1'b0;
        m_err  = 1'b0;
        m_code = 2'b00;
        len = {m_stream[1], m_stream[0]};
        x   = m_stream[0] ^ m_stream[1];
        if (len > 512) begin
            m_err  = 1'b1;
            m_code = 2'b01;
            return;
        end
        for (int w = 0; w < int'(len); w++) begin
            if (4 * w + 5 < n_avail) begin
                exp_addr.push_back(11'(4 * w));
                exp_data.push_back({m_stream[4*w+5], m_stream[4*w+4],
                                    m_stream[4*w+3], m_stream[4*w+2]});
            end
        end
        for (int i = 2; i < 2 + 4 * int'(len); i++) x ^= m_stream[i];
        if (2 + 4 * int'(len) < n_avail) begin
            if (m_stream[2 + 4 * len] == x) begin
                m_done = 1'b1;
            end else begin
                m_err  = 1'b1;
                m_code = 2'b10;
            end
        end
    endtask

    // Every write strobe must match the next predicted (addr, data).
    always @(negedge i_clk) begin
        if (!i_rst && o_imem_we) begin
            if (exp_addr.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: addr 0x%0h data 0x%0h with none pending",
                         o_imem_waddr, o_imem_wdata);
            end else begin
                check("write_addr", 32'(o_imem_waddr), 32'(exp_addr.pop_front()));
                check("write_data", o_imem_wdata, exp_data.pop_front());
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit rnd);
        int guard;
        if (rnd) begin
            for (int k = 0; k < 3 && $urandom_range(0, 1) == 1; k++) begin
                i_byte_valid = 1'b0;
                i_byte_data  = 8'($urandom);
                @(negedge i_clk);
            end
        end
        i_byte_valid = 1'b1;
        i_byte_data  = b;
        guard = 0;
        while (!o_byte_ready && guard < 100) begin
            @(negedge i_clk);
            guard++;
        end
        if (!o_byte_ready) begin
            total++;
            bad++;
            $display("FAIL byte_ready_timeout: ready 0 after %0d cycles, required 1", guard);
        end
        @(negedge i_clk);
        i_byte_valid = 1'b0;
    endtask

    task automatic start_pulse();
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        check("start_busy", 32'(o_busy), 32'd1);
        check("start_done_clr", 32'(o_done), 32'd0);
        check("start_err_clr", 32'(o_err), 32'd0);
        check("start_code_clr", 32'(o_err_code), 32'd0);
        check("start_core_rst", 32'(o_core_rst_n), 32'd0);
    endtask

    task automatic run_load(input int n_send, input bit rnd, input int mid_start_at);
        start_pulse();
        for (int i = 0; i < n_send; i++) begin
            if (i == mid_start_at) begin
                i_start = 1'b1;
                @(negedge i_clk);
                i_start = 1'b0;
                check("mid_start_ignored", 32'(o_busy), 32'd1);
            end
            if (i == m_stream.size() - 1) check("core_rst_before_csum", 32'(o_core_rst_n), 32'd0);
            send_byte(m_stream[i], rnd);
        end
    endtask

    task automatic check_status(input logic done, input logic err, input logic [1:0] code);
        check("status_done", 32'(o_done), 32'(done));
        check("status_err", 32'(o_err), 32'(err));
        check("status_code", 32'(o_err_code), 32'(code));
        check("status_core_rst_n", 32'(o_core_rst_n), 32'(done));
        check("status_busy", 32'(o_busy), 32'd0);
        check("status_ready", 32'(o_byte_ready), 32'd0);
    endtask

    task automatic drain();
        repeat (3) @(negedge i_clk);
        check("writes_pending", 32'(exp_addr.size()), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_we"}, 32'(o_imem_we), 32'd0);
        check({tag, "_waddr"}, 32'(o_imem_waddr), 32'd0);
        check({tag, "_wdata"}, o_imem_wdata, 32'd0);
        check({tag, "_ready"}, 32'(o_byte_ready), 32'd0);
        check({tag, "_busy"}, 32'(o_busy), 32'd0);
        check({tag, "_done"}, 32'(o_done), 32'd0);
        check({tag, "_err"}, 32'(o_err), 32'd0);
        check({tag, "_code"}, 32'(o_err_code), 32'd0);
        check({tag, "_core_rst_n"}, 32'(o_core_rst_n), 32'd0);
    endtask

    initial begin
        i_rst        = 1'b1;
        i_start      = 1'b0;
        i_byte_valid = 1'b0;
        i_byte_data  = 8'h00;
        repeat (2) @(negedge i_clk);
        check_all_zero("reset");
        i_rst = 1'b0;
        @(negedge i_clk);

        // N=2 good image; XOR of the 10 leading bytes is 0x73.
        m_stream = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
                     8'h13, 8'h01, 8'hA0, 8'h00, 8'h73};
        model_load(m_stream.size());
        check("pin_model_done", 32'(m_done), 32'd1);
        check("pin_model_word0", exp_data[0], 32'h0050_0093);
        check("pin_model_addr1", 32'(exp_addr[1]), 32'h004);
        run_load(m_stream.size(), 1'b0, -1);
        check_status(m_done, m_err, m_code);
        drain();

        // Same image, checksum bit 0 flipped.
        m_stream[10] = 8'h72;
        model_load(m_stream.size());
        check("pin_model_code_csum", 32'(m_code), 32'd2);
        run_load(m_stream.size(), 1'b0, -1);
        check_status(m_done, m_err, m_code);
        drain();

        // 513 words: overflow right after LEN_HI.
        m_stream = '{8'h01, 8'h02};
        model_load(m_stream.size());
        check("pin_model_code_ovf", 32'(m_code), 32'd1);
        run_load(m_stream.size(), 1'b0, -1);
        check_status(m_done, m_err, m_code);
        drain();

        // Empty image, then a one-word image 0xDEADBEEF (checksum 0x23).
        m_stream = '{8'h00, 8'h00, 8'h00};
        model_load(m_stream.size());
        run_load(m_stream.size(), 1'b0, -1);
        check_status(m_done, m_err, m_code);
        drain();
        m_stream = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h23};
        model_load(m_stream.size());
        check("pin_model_n1_done", 32'(m_done), 32'd1);
        run_load(m_stream.size(), 1'b0, -1);
        check_status(m_done, m_err, m_code);
        drain();

        // Good N=2 image with ragged valid and a stray start in the payload.
        m_stream = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
                     8'h13, 8'h01, 8'hA0, 8'h00, 8'h73};
        model_load(m_stream.size());
        run_load(m_stream.size(), 1'b1, 4);
        check_status(m_done, m_err, m_code);
        drain();

        // Reset after 6 payload bytes: one write seen, second never issued.
        model_load(8);
        check("pin_model_partial", 32'(exp_addr.size()), 32'd1);
        run_load(8, 1'b0, -1);
        #2 i_rst = 1'b1;
        #1 check_all_zero("midreset");
        i_byte_valid = 1'b1;
        i_byte_data  = 8'h55;
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;
        repeat (3) @(negedge i_clk);
        check("post_reset_ready", 32'(o_byte_ready), 32'd0);
        check("post_reset_busy", 32'(o_busy), 32'd0);
        i_byte_valid = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time writer for instruction memory; the core itself only ever reads imem.
- Accepts a byte stream (from a UART RX or a testbench) with a valid/ready handshake.
- Assembles little-endian 32-bit words and drives a single-port imem write interface with ascending byte addresses.
- Holds the core in reset until a complete, checksum-verified image has been written.

Parameters:
- P_DATA_WIDTH, 32: imem word width; fixed at 32.
- P_ADDR_WIDTH, 11: imem byte-address width. Capacity is 2**P_ADDR_WIDTH/4 words (512 at the default).

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst  input  1  reset; asynchronous, active-high.
- i_start  input  1  one-cycle load request.
- i_byte_valid  input  1  byte-stream valid.
- i_byte_data  input  8  byte-stream data.
- o_byte_ready  output  1  loader can accept a byte.
- o_imem_we  output  1  imem write strobe, one cycle per word.
- o_imem_waddr  output  P_ADDR_WIDTH  imem byte address, word aligned.
- o_imem_wdata  output  P_DATA_WIDTH  imem write word.
- o_core_rst_n  output  1  active-low reset to the core; low until a load succeeds.
- o_busy  output  1  load in progress.
- o_done  output  1  last load succeeded; sticky.
- o_err  output  1  last load failed; sticky.
- o_err_code  output  2  01 = length overflow, 10 = checksum mismatch, 00 = none.

Behaviour:
- Reset (asynchronous, active-high): state IDLE; every output 0, including o_core_rst_n (core held in reset). Internal counters, checksum and word register are cleared.
- A byte transfers on a rising edge where i_byte_valid && o_byte_ready. o_byte_ready is 1 only in LEN0, LEN1, DATA and CSUM. Upstream may hold i_byte_valid for any time; data is sampled only on a transfer.
- Stream format: LEN_LO, LEN_HI (16-bit word count N), then 4*N payload bytes (LSB first per word), then one CSUM byte. CSUM must equal the XOR of every byte before it, including the length bytes.
- FSM states:
  - IDLE: waiting for a request.
  - LEN0: capture LEN_LO.
  - LEN1: capture LEN_HI and check N.
  - DATA: receive payload bytes.
  - CSUM: receive and compare the checksum byte.
  - DONE: load succeeded.
  - ERR: load failed.
- IDLE, DONE, ERR on i_start → LEN0. On entry: o_done=0, o_err=0, o_err_code=00, o_core_rst_n=0, word address=0, checksum=0, o_busy=1.
- i_start is ignored while o_busy=1.
- LEN1 on transfer:
  - N > capacity → ERR, code 01.
  - N == 0 → CSUM.
  - Otherwise → DATA.
- DATA: byte k of a word goes into bits [8k+7:8k]. On the 4th byte's transfer edge, o_imem_wdata is loaded with the assembled word and o_imem_we=1 for exactly the next cycle, with o_imem_waddr = 4*word_index. The address advances by 4 after each write.
- After word N is accepted → CSUM. o_byte_ready may stay high; the write pulse never stalls the stream, so back-to-back bytes are allowed.
- CSUM on transfer:
  - Match → DONE: o_done=1, o_busy=0, o_core_rst_n=1 from the following cycle.
  - Mismatch → ERR, code 10: o_err=1, o_busy=0, o_core_rst_n stays 0.
- Overflow (code 01) also sets o_err=1 and o_busy=0 on entry to ERR.
- Word writes already performed before an error are not undone; the core stays in reset.
- Reset mid-load: everything returns to reset values immediately; any partial word is discarded and no write is issued.
- o_imem_waddr and o_imem_wdata hold their last values when o_imem_we=0.

Test Plan:
- Load N=2, words 0x00500093 and 0x00A00113, CSUM=XOR of the 10 preceding bytes:
  - writes (addr 0x000, 0x00500093) and (addr 0x004, 0x00A00113), each a one-cycle we.
  - o_done=1, o_core_rst_n rises one cycle after the CSUM transfer.
- Same stream with CSUM bit 0 flipped → o_err=1, o_err_code=10, o_core_rst_n=0, both writes still observed.
- LEN=0x0201 (513 > 512) → ERR with code 01 right after LEN_HI; no imem writes; o_byte_ready=0.
- N=0 with CSUM=0x00 → DONE, no writes. Then i_start with N=1 → o_done clears, o_core_rst_n returns to 0, a new load runs.
- i_byte_valid toggled randomly, plus an i_start pulse mid-load:
  - writes are identical to the continuous-valid case;
  - the mid-load i_start is ignored.
- Assert i_rst after 6 payload bytes of an N=2 load → all outputs 0 asynchronously; only one word write was seen before reset; state is IDLE.
